diff_stream_decoder: RTL and testbench

Receive-side counterpart of the free-running difference encoder. The encoder emits `Count = In - Cnt` (mod 256) every clock, where `Cnt` advances by 1 per clock. This block keeps a local replica of that counter, aligns it on a `Sync` pulse, and reconstructs `In = Count + Cnt` (mod 256). Decoded bytes go into a small FIFO and leave through a valid/ready output port. It sits at the far end of the encoder link, ahead of any downstream consumer that can stall.

---
 rtl/diff_stream_decoder_pkg.sv | 17 +
 rtl/sync_fifo_rs.sv | 54 +++++
 rtl/diff_stream_decoder.sv | 93 +++++++++
 tb/tb_diff_stream_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/diff_stream_decoder_pkg.sv
// Shared constants for the difference-stream decoder: data width, FSM state
// encoding and the modulo-256 reconstruction helper.
package diff_stream_decoder_pkg;

  localparam int DW = 8;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  // Undo the encoder's subtraction; the carry out of the top bit is discarded.
  function automatic logic [DW-1:0] decode_byte(input logic [DW-1:0] diff,
                                                input logic [DW-1:0] cnt);
    return diff + cnt;
  endfunction

endpackage

// File: rtl/sync_fifo_rs.sv
// Register-array FIFO with extended pointers; flush empties it and may accept
// a write into slot 0 in the same cycle.
module sync_fifo_rs #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          rd_ok;
  logic          wr_ok;
  logic          mem_we;
  logic [AW-1:0] mem_wa;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok  = rd_en && !empty;
  // A write into a full FIFO is accepted only when the head leaves this cycle.
  assign wr_ok  = wr_en && (!full || rd_ok);
  assign mem_we = flush ? wr_en : wr_ok;
  assign mem_wa = flush ? '0 : wr_ptr[AW-1:0];
  assign dout   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= {{AW{1'b0}}, wr_en};
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && mem_we) mem[mem_wa] <= din;
  end

endmodule

// File: rtl/diff_stream_decoder.sv
// Rebuilds In = Diff + Cnt from a free-running difference encoder, using a
// local counter aligned on Sync, and queues decoded bytes for a stalling sink.
module diff_stream_decoder
  import diff_stream_decoder_pkg::*;
#(
  parameter logic [7:0] SYNC_VAL = 8'd1,
  parameter int         DEPTH    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Sync,
  input  logic                 In_Valid,
  input  logic signed [DW-1:0] Diff,
  output logic [DW-1:0]        Out_Data,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic                 Locked,
  output logic                 Overflow,
  output logic [1:0]           State
);

  // Output handshake: Out_Data is offered whenever Out_Valid is high, a byte
  // is consumed only in a cycle where Out_Valid && Out_Ready, and Out_Data
  // holds steady while Out_Valid is high and Out_Ready is low.

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_eff;
  logic [DW-1:0] dec;
  logic          push;
  logic          pop;
  logic          drop;
  logic          flush;
  logic          fifo_wr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow_q;

  assign cnt_eff = Sync ? SYNC_VAL : cnt_q;
  assign dec     = decode_byte($unsigned(Diff), cnt_eff);

  assign push    = In_Valid && ((state_q == ST_LOCKED) || Sync);
  assign pop     = Out_Valid && Out_Ready;
  assign flush   = Sync && (state_q == ST_ERROR);
  assign drop    = push && fifo_full && !pop && !flush;
  assign fifo_wr = push && !drop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (Sync) state_d = ST_LOCKED;
      ST_LOCKED:   if (drop) state_d = ST_ERROR;
      ST_ERROR:    if (Sync) state_d = ST_LOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_UNLOCKED;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // The encoder free-runs, so the replica advances regardless of In_Valid.
      if (Sync || (state_q != ST_UNLOCKED)) cnt_q <= cnt_eff + 1'b1;
      if (flush)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
    end
  end

  sync_fifo_rs #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .flush (flush),
    .wr_en (fifo_wr),
    .din   (dec),
    .rd_en (pop),
    .dout  (Out_Data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Out_Valid = !fifo_empty;
  assign Locked    = (state_q == ST_LOCKED);
  assign Overflow  = overflow_q;
  assign State     = state_q;

endmodule

// File: tb/tb_diff_stream_decoder.sv
// Directed bench for diff_stream_decoder: lock/decode, encoder model across the
// counter wrap, overflow, ERROR recovery, realign and mid-stream reset.
module tb_diff_stream_decoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Sync;
  logic        In_Valid;
  logic [7:0]  Diff;
  logic [7:0]  Out_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Locked;
  logic        Overflow;
  logic [1:0]  State;

  int tests = 0;
  int fails = 0;

  logic [7:0] enc_cnt;
  logic [7:0] enc_in;
  logic [7:0] exp_b;

  always #5 CLK = ~CLK;

  diff_stream_decoder #(
    .SYNC_VAL (8'd1),
    .DEPTH    (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Sync      (Sync),
    .In_Valid  (In_Valid),
    .Diff      (Diff),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Locked    (Locked),
    .Overflow  (Overflow),
    .State     (State)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; Sync = 1'b0; In_Valid = 1'b0; Diff = 8'h00; Out_Ready = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check("rst_valid", {7'd0, Out_Valid}, 8'h00);
    check("rst_data", Out_Data, 8'h00);
    check("rst_locked", {7'd0, Locked}, 8'h00);
    check("rst_overflow", {7'd0, Overflow}, 8'h00);
    check("rst_state", {6'd0, State}, 8'h00);

    // Unlocked samples are discarded.
    In_Valid = 1'b1; Diff = 8'h44; Out_Ready = 1'b1;
    tick(); tick();
    check("unlocked_discard", {7'd0, Out_Valid}, 8'h00);

    // Lock and decode: counter 1,2,3 against 5,4,3 gives 6 each time.
    Sync = 1'b1; Diff = 8'h05; tick();
    Sync = 1'b0;
    check("lock_locked", {7'd0, Locked}, 8'h01);
    check("lock_valid0", {7'd0, Out_Valid}, 8'h01);
    check("lock_data0", Out_Data, 8'h06);
    Diff = 8'h04; tick();
    check("lock_data1", Out_Data, 8'h06);
    Diff = 8'h03; tick();
    check("lock_data2", Out_Data, 8'h06);
    In_Valid = 1'b0; tick();
    check("lock_drained", {7'd0, Out_Valid}, 8'h00);

    // Encoder model, reset aligned, In=0x80, with a wrap-boundary probe.
    RST = 1'b1; tick(); RST = 1'b0;
    Out_Ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      enc_cnt = 8'(k + 1);
      enc_in  = 8'h80;
      exp_b   = 8'h80;
      if (k == 254) begin
        Diff = 8'h02; exp_b = 8'h01;
      end else if (k == 255) begin
        Diff = 8'h03; exp_b = 8'h03;
      end else begin
        Diff = enc_in - enc_cnt;
      end
      Sync = (k == 0); In_Valid = 1'b1;
      tick();
      check("model_valid", {7'd0, Out_Valid}, 8'h01);
      check("model_data", Out_Data, exp_b);
    end
    Sync = 1'b0; In_Valid = 1'b0; tick();
    check("model_drained", {7'd0, Out_Valid}, 8'h00);

    // Overflow: 5 samples with the sink stalled, counter realigned to 1.
    Out_Ready = 1'b0; In_Valid = 1'b1; Diff = 8'h10; Sync = 1'b1; tick();
    Sync = 1'b0; tick(); tick(); tick();
    check("ovf_head_full", Out_Data, 8'h11);
    check("ovf_locked_before", {7'd0, Locked}, 8'h01);
    check("ovf_flag_before", {7'd0, Overflow}, 8'h00);
    tick();
    check("ovf_flag", {7'd0, Overflow}, 8'h01);
    check("ovf_locked", {7'd0, Locked}, 8'h00);
    check("ovf_state", {6'd0, State}, 8'h02);
    check("ovf_head_kept", Out_Data, 8'h11);
    // Drain while samples keep arriving; ERROR must not push them.
    Out_Ready = 1'b1; Diff = 8'h77;
    tick(); check("drain_1", Out_Data, 8'h12);
    tick(); check("drain_2", Out_Data, 8'h13);
    tick(); check("drain_3", Out_Data, 8'h14);
    tick(); check("drain_empty", {7'd0, Out_Valid}, 8'h00);
    check("drain_ovf_sticky", {7'd0, Overflow}, 8'h01);

    // Re-enter LOCKED from an empty ERROR and overflow again.
    Out_Ready = 1'b0; Sync = 1'b1; Diff = 8'h20; tick();
    Sync = 1'b0;
    check("relock_locked", {7'd0, Locked}, 8'h01);
    check("relock_ovf", {7'd0, Overflow}, 8'h00);
    check("relock_data", Out_Data, 8'h21);
    tick(); tick(); tick(); tick();
    check("ovf2_flag", {7'd0, Overflow}, 8'h01);
    In_Valid = 1'b0; Out_Ready = 1'b1;
    tick(); tick();
    check("ovf2_two_left", Out_Data, 8'h23);

    // Recovery: flush the 2 queued bytes, push the Sync sample.
    Out_Ready = 1'b0; Sync = 1'b1; In_Valid = 1'b1; Diff = 8'h10; tick();
    Sync = 1'b0; In_Valid = 1'b0;
    check("recover_data", Out_Data, 8'h11);
    check("recover_valid", {7'd0, Out_Valid}, 8'h01);
    check("recover_ovf", {7'd0, Overflow}, 8'h00);
    check("recover_locked", {7'd0, Locked}, 8'h01);
    Out_Ready = 1'b1; tick();
    check("recover_flushed", {7'd0, Out_Valid}, 8'h00);

    // Counter is now 3: queue 0x03, 0x04, 0x05 then reset (overriding Sync).
    Out_Ready = 1'b0; In_Valid = 1'b1; Diff = 8'h00;
    tick(); tick(); tick();
    check("queue3_head", Out_Data, 8'h03);
    RST = 1'b1; Sync = 1'b1; tick();
    RST = 1'b0; Sync = 1'b0;
    check("midrst_valid", {7'd0, Out_Valid}, 8'h00);
    check("midrst_locked", {7'd0, Locked}, 8'h00);
    check("midrst_data", Out_Data, 8'h00);
    check("midrst_ovf", {7'd0, Overflow}, 8'h00);
    Diff = 8'h33; tick(); tick();
    check("midrst_ignored", {7'd0, Out_Valid}, 8'h00);

    // Relock, then realign while LOCKED without flushing.
    Sync = 1'b1; tick();
    Sync = 1'b0;
    check("relock2_data", Out_Data, 8'h34);
    Diff = 8'h00; tick();
    Sync = 1'b1; tick();
    Sync = 1'b0; In_Valid = 1'b0;
    check("realign_locked", {7'd0, Locked}, 8'h01);
    check("realign_head", Out_Data, 8'h34);
    Out_Ready = 1'b1;
    tick(); check("realign_q1", Out_Data, 8'h02);
    tick(); check("realign_q2", Out_Data, 8'h01);
    tick(); check("realign_empty", {7'd0, Out_Valid}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
